ifetch_line_seq: RTL and testbench

//  Fetch sequencer for the 128-bit I-cache line datapath. Issues line read requests,

---
 rtl/ifetch_line_seq.sv | 170 +++++++++++++++++
 tb/tb_ifetch_line_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_line_seq.sv
// Fetch line sequencer: requests 128-bit I-cache lines and drains them to decode as
// instruction pairs. Optional stall counter port enabled by IFETCH_SEQ_STALL_CNT_EN.
module ifetch_line_seq #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic              req_valid,
  output logic [PC_W-1:0]   req_pc,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [127:0]      resp_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst0,
  output logic [31:0]       out_inst1,
  output logic [PC_W-1:0]   out_pc0,
  output logic [1:0]        out_mask
`ifdef IFETCH_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  localparam logic [PC_W-5:0] BASE_ONE = 1;

  logic [2:0]      r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [127:0]    r_line;
  logic [PC_W-5:0] r_base;
  logic [1:0]      r_off;

  logic [2:0]      w_state_nxt;
  logic [PC_W-1:0] w_fetch_pc_nxt;
  logic [127:0]    w_line_nxt;
  logic [PC_W-5:0] w_base_nxt;
  logic [1:0]      w_off_nxt;
  logic            w_drain;
  logic            w_last_pair;

  function automatic logic [31:0] f_word(input logic [127:0] line, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

  assign w_drain     = (r_state == S_DRAIN);
  assign w_last_pair = r_off[1];

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_line_nxt     = r_line;
    w_base_nxt     = r_base;
    w_off_nxt      = r_off;
    if (flush) begin
      // Leaving DRAIN is what invalidates the buffered line; its data is simply ignored.
      w_fetch_pc_nxt = flush_pc;
      case (r_state)
        S_WAIT:  w_state_nxt = resp_valid ? S_REQ : S_DROP;
        S_REQ:   w_state_nxt = req_ready  ? S_DROP : S_REQ;
        // Stay in DROP for the owed response, unless it lands in this very cycle.
        S_DROP:  w_state_nxt = resp_valid ? S_REQ : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (req_ready) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (resp_valid) begin
            w_line_nxt  = resp_line;
            w_base_nxt  = r_fetch_pc[PC_W-1:4];
            w_off_nxt   = r_fetch_pc[3:2];
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (w_last_pair) begin
              w_fetch_pc_nxt = {r_base + BASE_ONE, 4'b0000};
              w_state_nxt    = S_REQ;
            end else begin
              w_off_nxt = r_off + 2'd2;
            end
          end
        end
        S_DROP: begin
          if (resp_valid) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_line     <= '0;
      r_base     <= '0;
      r_off      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_line     <= w_line_nxt;
      r_base     <= w_base_nxt;
      r_off      <= w_off_nxt;
    end
  end

  // Decode-facing outputs are forced to zero outside DRAIN so stale data never leaks.
  always_comb begin
    req_valid = (r_state == S_REQ);
    req_pc    = (r_state == S_REQ) ? r_fetch_pc : '0;
    out_valid = w_drain;
    out_inst0 = '0;
    out_inst1 = '0;
    out_pc0   = '0;
    out_mask  = 2'b00;
    if (w_drain) begin
      out_inst0 = f_word(r_line, r_off);
      out_pc0   = {r_base, r_off, 2'b00};
      if (r_off == 2'd3) begin
        out_mask = 2'b01;
      end else begin
        out_inst1 = f_word(r_line, r_off + 2'd1);
        out_mask  = 2'b11;
      end
    end
  end

`ifdef IFETCH_SEQ_STALL_CNT_EN
  function automatic logic [31:0] f_sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hffffffff) ? cnt : cnt + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;
  logic        w_starved;

  assign w_starved = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_DROP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (w_starved) begin
      r_stall_cnt <= f_sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch_line_seq.sv
// Directed bench for ifetch_line_seq with request/output scoreboards.
module tb_ifetch_line_seq;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  flush_pc = '0;
  logic         req_ready = 1'b0;
  logic         resp_valid = 1'b0;
  logic [127:0] resp_line = '0;
  logic         out_ready = 1'b0;
  logic         req_valid;
  logic [31:0]  req_pc;
  logic         out_valid;
  logic [31:0]  out_inst0;
  logic [31:0]  out_inst1;
  logic [31:0]  out_pc0;
  logic [1:0]   out_mask;
`ifdef IFETCH_SEQ_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
    logic [1:0]  m;
  } exp_t;

  exp_t        out_q[$];
  logic [31:0] req_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  ifetch_line_seq dut (
    .clk(clk), .rstn(rstn), .flush(flush), .flush_pc(flush_pc),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_line(resp_line),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst0(out_inst0), .out_inst1(out_inst1), .out_pc0(out_pc0), .out_mask(out_mask)
`ifdef IFETCH_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input exp_t e);
    chk("out_valid", {31'b0, out_valid}, 32'd1);
    chk("out_inst0", out_inst0, e.i0);
    chk("out_inst1", out_inst1, e.i1);
    chk("out_pc0",   out_pc0,   e.pc);
    chk("out_mask",  {30'b0, out_mask}, {30'b0, e.m});
  endtask

  task automatic chk_quiet(input bit exp_req);
    chk("out_valid_low", {31'b0, out_valid}, 32'd0);
    chk("out_mask_low",  {30'b0, out_mask}, 32'd0);
    chk("req_valid_st",  {31'b0, req_valid}, {31'b0, exp_req});
  endtask

  task automatic wait_req(input bit accept);
    logic [31:0] e;
    for (int i = 0; i < 20 && req_valid !== 1'b1; i++) @(negedge clk);
    chk("req_valid", {31'b0, req_valid}, 32'd1);
    e = req_q.pop_front();
    chk("req_pc", req_pc, e);
    if (accept) begin
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
    end
  endtask

  task automatic send_resp(input logic [127:0] line, input int gap, input bit fl,
                           input logic [31:0] fpc);
    repeat (gap) @(negedge clk);
    resp_valid = 1'b1;
    resp_line  = line;
    flush      = fl;
    flush_pc   = fpc;
    @(negedge clk);
    resp_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic drain_one(input bit fl, input logic [31:0] fpc);
    exp_t e;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    e = out_q.pop_front();
    chk_out(e);
    out_ready = 1'b1;
    flush     = fl;
    flush_pc  = fpc;
    @(negedge clk);
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic flush_now(input logic [31:0] fpc, input bit rdy);
    flush     = 1'b1;
    flush_pc  = fpc;
    req_ready = rdy;
    @(negedge clk);
    flush     = 1'b0;
    req_ready = 1'b0;
  endtask

  function automatic logic [127:0] mkline(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  initial begin
    logic [127:0] l1, l2, l3, l4, l6, l7;
    exp_t         held;
    l1 = mkline(32'h1111_0000);
    l2 = mkline(32'h2222_0000);
    l3 = mkline(32'h3333_0000);
    l4 = mkline(32'h4444_0000);
    l6 = mkline(32'h6666_0000);
    l7 = mkline(32'h7777_0000);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_pc", req_pc, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_mask", {30'b0, out_mask}, 32'd0);
    chk("rst_out_pc0", out_pc0, 32'd0);
    chk("rst_out_inst0", out_inst0, 32'd0);
    chk("rst_out_inst1", out_inst1, 32'd0);
    rstn = 1'b1;

    // test 1: sequential fetch of first line
    req_q.push_back(32'h1c000000);
    out_q.push_back('{32'h1111_0000, 32'h1111_0001, 32'h1c000000, 2'b11});
    out_q.push_back('{32'h1111_0002, 32'h1111_0003, 32'h1c000008, 2'b11});
    req_q.push_back(32'h1c000010);
    wait_req(1'b1);
    send_resp(l1, 2, 1'b0, 32'd0);
`ifdef IFETCH_SEQ_STALL_CNT_EN
    // one REQ cycle plus three WAIT cycles
    chk("stall_cnt", stall_cnt, 32'd4);
`endif
    drain_one(1'b0, 32'd0);
    drain_one(1'b0, 32'd0);

    // test 2: flush in DRAIN (with simultaneous handshake) to a word-3 target
    wait_req(1'b1);
    out_q.push_back('{32'h2222_0000, 32'h2222_0001, 32'h1c000010, 2'b11});
    send_resp(l2, 0, 1'b0, 32'd0);
    drain_one(1'b1, 32'h1c00002c);
    chk_quiet(1'b1);
    req_q.push_back(32'h1c00002c);
    wait_req(1'b1);
    out_q.push_back('{32'h3333_0003, 32'h0000_0000, 32'h1c00002c, 2'b01});
    req_q.push_back(32'h1c000030);
    send_resp(l3, 1, 1'b0, 32'd0);
    drain_one(1'b0, 32'd0);

    // test 3: backpressure at offset 1
    wait_req(1'b0);
    flush_now(32'h1c000034, 1'b0);
    req_q.push_back(32'h1c000034);
    wait_req(1'b1);
    out_q.push_back('{32'h4444_0001, 32'h4444_0002, 32'h1c000034, 2'b11});
    out_q.push_back('{32'h4444_0003, 32'h0000_0000, 32'h1c00003c, 2'b01});
    send_resp(l4, 0, 1'b0, 32'd0);
    held = out_q[0];
    for (int i = 0; i < 5; i++) begin
      chk_out(held);
      @(negedge clk);
    end
    drain_one(1'b0, 32'd0);
    chk("adv_pc0", out_pc0, 32'h1c00003c);
    drain_one(1'b0, 32'd0);

    // test 4: flush in WAIT, stale response three cycles later
    req_q.push_back(32'h1c000040);
    wait_req(1'b1);
    flush_now(32'h1c000100, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk_quiet(1'b0);
      @(negedge clk);
    end
    send_resp(mkline(32'hdead_0000), 0, 1'b0, 32'd0);
    chk_quiet(1'b1);
    req_q.push_back(32'h1c000100);
    wait_req(1'b1);

    // test 5: flush coincident with response, then flush coincident with req_ready
    send_resp(mkline(32'hbeef_0000), 0, 1'b1, 32'h1c000200);
    chk_quiet(1'b1);
    req_q.push_back(32'h1c000200);
    wait_req(1'b0);
    flush_now(32'h1c000300, 1'b1);
    chk_quiet(1'b0);
    @(negedge clk);
    chk_quiet(1'b0);
    send_resp(mkline(32'hbad0_0000), 0, 1'b0, 32'd0);
    chk_quiet(1'b1);
    req_q.push_back(32'h1c000300);
    wait_req(1'b0);

    // unsolicited response in REQ is ignored
    send_resp(mkline(32'hcafe_0000), 0, 1'b0, 32'd0);
    chk_quiet(1'b1);
    req_q.push_back(32'h1c000300);
    wait_req(1'b0);

    // test 6: PC wrap at the top of the address space
    flush_now(32'hfffffff8, 1'b0);
    req_q.push_back(32'hfffffff8);
    wait_req(1'b1);
    out_q.push_back('{32'h6666_0002, 32'h6666_0003, 32'hfffffff8, 2'b11});
    req_q.push_back(32'h0000_0000);
    send_resp(l6, 0, 1'b0, 32'd0);
    drain_one(1'b0, 32'd0);
    wait_req(1'b1);

    // reset asserted while a line is being drained
    send_resp(l7, 0, 1'b0, 32'd0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_pc0", out_pc0, 32'h0000_0000);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("mid_rst_inst0", out_inst0, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    req_q.push_back(32'h1c000000);
    wait_req(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
